scan_display: RTL and testbench
===============================

SCAN_DISPLAY -- requirements
Module: scan_display

Interface
REQ-001 SHALL have parameter DIV, default 50000: Clk cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 4: blanking cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports Din0..Din7, input, 4 bits each: hex digits from the shift register; Din7 is the most significant, Din0 the newest.
REQ-006 SHALL have port En, input, 1 bit: display enable.
REQ-007 SHALL have port AN, output, 8 bits: active-low digit selects; AN[i] drives digit i.
REQ-008 SHALL have port SEG, output, 7 bits: active-low segments; SEG[0]=a through SEG[6]=g.
REQ-009 SHALL have port Frame, output, 1 bit: one-cycle pulse when the shadow registers load.

Function
REQ-010 SHALL use a prescaler cnt counting 0..DIV-1 and wrapping to 0; tick = (cnt==DIV-1) and En.
REQ-011 SHALL use a 3-bit slot index idx that increments on tick and wraps 7->0.
REQ-012 SHALL copy Din0..Din7 into eight 4-bit shadow registers on a tick with idx==7, and SHALL pulse Frame high in the following cycle.
- Din changes within a frame SHALL NOT alter the displayed digits until the next load (no tearing).
REQ-013 SHALL register AN and SEG, so that both reflect the cnt, idx and shadow values of the previous cycle (latency 1 cycle).
REQ-014 SHALL drive AN = all ones except bit idx, which SHALL be low when En=1 and cnt>=BLANK_CYC; during cnt<BLANK_CYC, AN SHALL be 8'hFF.
REQ-015 SHALL set SEG to the hex decode of shadow[idx] in standard 0-F glyphs, active-low.
- Values: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-016 SHALL behave as follows when En=0:
- cnt is held at 0 and idx is held.
- No ticks or loads occur.
- AN=8'hFF and SEG=7'h7F from the next cycle.
- When En returns to 1, scanning resumes from the held idx.
REQ-017 SHALL give BLANK_CYC=0 no blanking: the slot digit is driven for all DIV cycles.

Reset
REQ-018 On Rst high, SHALL asynchronously set cnt=0, idx=0, all shadows=0, AN=8'hFF, SEG=7'h7F and Frame=0.
REQ-019 On a mid-frame Rst, SHALL discard the partial scan; after Rst falls, scanning SHALL restart at slot 0 showing zeros until the first load.

Configuration
REQ-020 The macro LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-021 When LEADING_ZERO_BLANK_EN is defined:
- Digit i (i>=1) SHALL be blanked (AN[i] high, SEG=7'h7F) during its slot when shadow[i] and all shadow[j] with j>i are 0.
- Digit 0 SHALL always be shown.
REQ-022 When LEADING_ZERO_BLANK_EN is undefined, all eight digits SHALL be shown, including leading zeros.

Verification (DIV=4, BLANK_CYC=1 unless noted)
REQ-023 Reset then En=1 -> AN sequence FE,FD,FB,...,7F repeating every 32 cycles, with AN=FF for 1 cycle per slot; SEG=7'h40 in every slot before the first load.
REQ-024 Din7..Din0=8'h12345678-style digits 1..8 (Din0=8, Din7=1) held across a load -> Frame pulses once; next frame slot 0 SEG=7'h00 ('8') and slot 7 SEG=7'h79 ('1').
REQ-025 Change Din0 from 3 to F mid-frame -> displayed slot 0 stays 7'h30 until the next Frame pulse, then becomes 7'h0E.
REQ-026 En=0 at idx=5 for 10 cycles -> AN=FF, SEG=7F, no Frame; on En=1 the scan resumes at slot 5.
REQ-027 With LEADING_ZERO_BLANK_EN, Din7..Din0=0,0,0,0,0,0,4,0 -> slots 7..2 show AN=FF, slot 1 shows '4', slot 0 shows '0'; all-zero input -> only digit 0 lit.
REQ-028 Rst asserted at idx=3 mid-slot -> AN=FF and SEG=7F immediately; after release, the scan starts at slot 0.

Source files
------------

// File: rtl/scan_display.sv
// scan_display: eight-digit multiplexed 7-segment scanner. Digits are latched into shadow registers once per frame.
// Define LEADING_ZERO_BLANK_EN at build time to blank leading zeros; it is off by default.
module scan_display #(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [3:0] Din0,
   input  logic [3:0] Din1,
   input  logic [3:0] Din2,
   input  logic [3:0] Din3,
   input  logic [3:0] Din4,
   input  logic [3:0] Din5,
   input  logic [3:0] Din6,
   input  logic [3:0] Din7,
   input  logic       En,
   output logic [7:0] AN,
   output logic [6:0] SEG,
   output logic       Frame
);

   localparam logic [15:0] CNT_MAX   = 16'(DIV - 1);
   localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYC);

   logic [15:0] r_cnt;
   logic [2:0]  r_idx;
   logic [3:0]  r_shadow [8];
   logic [7:0]  r_an;
   logic [6:0]  r_seg;
   logic        r_frame;

   logic [3:0]  w_din [8];
   logic        w_tick;
   logic        w_load;
   logic        w_blank;
   logic        w_lz_off;
   logic [3:0]  w_digit;
   logic [6:0]  w_glyph;
   logic [7:0]  w_an_next;
   logic [6:0]  w_seg_next;

   assign w_din[0] = Din0;
   assign w_din[1] = Din1;
   assign w_din[2] = Din2;
   assign w_din[3] = Din3;
   assign w_din[4] = Din4;
   assign w_din[5] = Din5;
   assign w_din[6] = Din6;
   assign w_din[7] = Din7;

   assign w_tick  = En && (r_cnt == CNT_MAX);
   assign w_load  = w_tick && (r_idx == 3'd7);
   assign w_digit = r_shadow[r_idx];

   generate
      if (BLANK_CYC == 0) begin : g_no_blank
         assign w_blank = 1'b0;
      end else begin : g_blank
         assign w_blank = (r_cnt < BLANK_LIM);
      end
   endgenerate

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more significant shadow digit are zero.
   logic [7:0] w_zero;
   logic [7:0] w_lead_zero;
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lz
         assign w_zero[gi] = (r_shadow[gi] == 4'h0);
         if (gi == 0) begin : g_lsd
            assign w_lead_zero[gi] = 1'b0;
         end else begin : g_upper
            assign w_lead_zero[gi] = &w_zero[7:gi];
         end
      end
   endgenerate
   assign w_lz_off = w_lead_zero[r_idx];
`else
   assign w_lz_off = 1'b0;
`endif

   always_comb begin
      w_glyph = 7'h7F;
      case (w_digit)
         4'h0: w_glyph = 7'h40;
         4'h1: w_glyph = 7'h79;
         4'h2: w_glyph = 7'h24;
         4'h3: w_glyph = 7'h30;
         4'h4: w_glyph = 7'h19;
         4'h5: w_glyph = 7'h12;
         4'h6: w_glyph = 7'h02;
         4'h7: w_glyph = 7'h78;
         4'h8: w_glyph = 7'h00;
         4'h9: w_glyph = 7'h10;
         4'hA: w_glyph = 7'h08;
         4'hB: w_glyph = 7'h03;
         4'hC: w_glyph = 7'h46;
         4'hD: w_glyph = 7'h21;
         4'hE: w_glyph = 7'h06;
         4'hF: w_glyph = 7'h0E;
         default: w_glyph = 7'h7F;
      endcase
   end

   // Segments stay valid through the blanking window; only the anode is held off.
   always_comb begin
      w_an_next  = 8'hFF;
      w_seg_next = 7'h7F;
      if (En && !w_lz_off) begin
         w_seg_next = w_glyph;
         if (!w_blank) begin
            w_an_next = ~(8'h01 << r_idx);
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_an    <= 8'hFF;
         r_seg   <= 7'h7F;
         r_frame <= 1'b0;
      end else begin
         r_an    <= w_an_next;
         r_seg   <= w_seg_next;
         r_frame <= w_load;
         if (!En || (r_cnt == CNT_MAX)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (w_tick) begin
            r_idx <= r_idx + 3'd1;
         end
      end
   end

   genvar si;
   generate
      for (si = 0; si < 8; si++) begin : g_shadow
         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
               r_shadow[si] <= 4'h0;
            end else if (w_load) begin
               r_shadow[si] <= w_din[si];
            end
         end
      end
   endgenerate

   assign AN    = r_an;
   assign SEG   = r_seg;
   assign Frame = r_frame;

endmodule

// File: tb/tb_scan_display.sv
// Bench for scan_display: glyph table vectors, directed frame/enable/reset sequences and a randomized run
// checked every cycle against a frame-position model of the display.
module tb_scan_display;

   localparam int DIV       = 4;
   localparam int BLANK     = 1;
   localparam int FRAME_LEN = 8 * DIV;

   logic       Clk;
   logic       Rst;
   logic       En;
   logic [3:0] din [8];
   logic [7:0] AN;
   logic [6:0] SEG;
   logic       Frame;

   int n_checks = 0;
   int n_errors = 0;

   scan_display #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
      .Clk(Clk), .Rst(Rst),
      .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
      .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
      .En(En), .AN(AN), .SEG(SEG), .Frame(Frame)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0] val;
      logic [6:0] seg;
   } vec_t;

   vec_t       tbl [16];
   logic [6:0] glyph_tab [16];

   // Model: position within the frame (enabled cycles since the frame began) plus the latched digits.
   int         m_pos;
   logic [3:0] m_sh [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit lead_blank(input int i);
`ifdef LEADING_ZERO_BLANK_EN
      if (i == 0) return 1'b0;
      for (int j = i; j < 8; j++) if (m_sh[j] != 4'h0) return 1'b0;
      return 1'b1;
`else
      return (i < 0);
`endif
   endfunction

   task automatic model_reset();
      m_pos = 0;
      for (int i = 0; i < 8; i++) m_sh[i] = 4'h0;
   endtask

   task automatic model_expect(output logic [7:0] ea, output logic [6:0] es, output logic ef);
      int idx;
      int cnt;
      idx = m_pos / DIV;
      cnt = m_pos % DIV;
      ea = 8'hFF;
      es = 7'h7F;
      ef = En && (m_pos == FRAME_LEN - 1);
      if (En && !lead_blank(idx)) begin
         es = glyph_tab[m_sh[idx]];
         if (cnt >= BLANK) ea[idx] = 1'b0;
      end
   endtask

   task automatic model_advance();
      if (En) begin
         if (m_pos == FRAME_LEN - 1)
            for (int i = 0; i < 8; i++) m_sh[i] = din[i];
         m_pos = (m_pos + 1) % FRAME_LEN;
      end else begin
         m_pos = (m_pos / DIV) * DIV;
      end
   endtask

   task automatic cycle();
      logic [7:0] ea;
      logic [6:0] es;
      logic       ef;
      model_expect(ea, es, ef);
      @(posedge Clk);
      #1;
      model_advance();
      chk("an", 32'(AN), 32'(ea));
      chk("seg", 32'(SEG), 32'(es));
      chk("frame", 32'(Frame), 32'(ef));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_frame();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 3 * FRAME_LEN && !found; i++) begin
         cycle();
         if (Frame) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_errors++;
         $display("FAIL frame_wait: no Frame pulse within %0d cycles", 3 * FRAME_LEN);
      end
   endtask

   task automatic wait_pos(input int pos);
      bit found;
      found = (m_pos == pos);
      for (int i = 0; i < 2 * FRAME_LEN && !found; i++) begin
         cycle();
         if (m_pos == pos) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_errors++;
         $display("FAIL pos_wait: position %0d not reached", pos);
      end
   endtask

   // Called just after an active edge: reset lands mid-cycle, away from any edge.
   task automatic do_reset();
      #2;
      Rst = 1'b1;
      #1;
      chk("rst_an", 32'(AN), 32'h0000_00FF);
      chk("rst_seg", 32'(SEG), 32'h0000_007F);
      chk("rst_frame", 32'(Frame), 32'h0);
      model_reset();
      @(posedge Clk);
      #1;
      chk("rst_hold_an", 32'(AN), 32'h0000_00FF);
      Rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{4'h0, 7'h40}; tbl[1]  = '{4'h1, 7'h79};
      tbl[2]  = '{4'h2, 7'h24}; tbl[3]  = '{4'h3, 7'h30};
      tbl[4]  = '{4'h4, 7'h19}; tbl[5]  = '{4'h5, 7'h12};
      tbl[6]  = '{4'h6, 7'h02}; tbl[7]  = '{4'h7, 7'h78};
      tbl[8]  = '{4'h8, 7'h00}; tbl[9]  = '{4'h9, 7'h10};
      tbl[10] = '{4'hA, 7'h08}; tbl[11] = '{4'hB, 7'h03};
      tbl[12] = '{4'hC, 7'h46}; tbl[13] = '{4'hD, 7'h21};
      tbl[14] = '{4'hE, 7'h06}; tbl[15] = '{4'hF, 7'h0E};
      for (int i = 0; i < 16; i++) glyph_tab[tbl[i].val] = tbl[i].seg;

      Rst = 1'b1;
      En  = 1'b0;
      for (int i = 0; i < 8; i++) din[i] = 4'h0;
      model_reset();
      #3;
      chk("init_an", 32'(AN), 32'h0000_00FF);
      chk("init_seg", 32'(SEG), 32'h0000_007F);
      chk("init_frame", 32'(Frame), 32'h0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;

      // Scan from reset: blank cycle, then digit 0 showing zero, then digit 1.
      En = 1'b1;
      cycle();
      chk("scan_blank_an", 32'(AN), 32'h0000_00FF);
      chk("scan_seg0", 32'(SEG), 32'h0000_0040);
      cycle();
      chk("scan_an0", 32'(AN), 32'h0000_00FE);
      run(4);
      chk("scan_an1", 32'(AN), 32'h0000_00FD);
      $display("scan from reset: AN=%h SEG=%h", AN, SEG);

      // Glyph table: load every digit with the same value, inspect slot 0.
      for (int v = 0; v < 16; v++) begin
         for (int i = 0; i < 8; i++) din[i] = tbl[v].val;
         wait_frame();
         run(2);
         chk("tbl_seg", 32'(SEG), 32'(tbl[v].seg));
         chk("tbl_an", 32'(AN), 32'h0000_00FE);
         $display("vec %0d: digit %h SEG=%h AN=%h", v, tbl[v].val, SEG, AN);
      end

      // Digits 1..8 (Din0=8, Din7=1).
      for (int i = 0; i < 8; i++) din[i] = 4'(8 - i);
      wait_frame();
      run(2);
      chk("d8_slot0_seg", 32'(SEG), 32'h0000_0000);
      run(28);
      chk("d1_slot7_seg", 32'(SEG), 32'h0000_0079);
      chk("d1_slot7_an", 32'(AN), 32'h0000_007F);
      $display("digits 1..8: slot7 SEG=%h AN=%h", SEG, AN);

      // Din0 changes mid-frame: slot 0 keeps the old glyph until the next load.
      for (int i = 1; i < 8; i++) din[i] = 4'(i);
      din[0] = 4'h3;
      wait_frame();
      din[0] = 4'hF;
      run(2);
      chk("tear_old", 32'(SEG), 32'h0000_0030);
      wait_frame();
      run(2);
      chk("tear_new", 32'(SEG), 32'h0000_000E);
      $display("no-tear: slot0 SEG=%h after reload", SEG);

      // Enable dropped at slot 5 for 10 cycles.
      wait_pos(5 * DIV + 2);
      En = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("dis_an", 32'(AN), 32'h0000_00FF);
         chk("dis_seg", 32'(SEG), 32'h0000_007F);
      end
      En = 1'b1;
      run(2);
      chk("resume_an5", 32'(AN), 32'h0000_00DF);
      $display("resume after disable: AN=%h", AN);

      // Leading zeros: only digit 1 nonzero.
      for (int i = 0; i < 8; i++) din[i] = 4'h0;
      din[1] = 4'h4;
      wait_frame();
      run(2);
      chk("lz_slot0_seg", 32'(SEG), 32'h0000_0040);
      chk("lz_slot0_an", 32'(AN), 32'h0000_00FE);
      run(4);
      chk("lz_slot1_seg", 32'(SEG), 32'h0000_0019);
      chk("lz_slot1_an", 32'(AN), 32'h0000_00FD);
      run(4);
`ifdef LEADING_ZERO_BLANK_EN
      chk("lz_slot2_an", 32'(AN), 32'h0000_00FF);
      chk("lz_slot2_seg", 32'(SEG), 32'h0000_007F);
`else
      chk("lz_slot2_an", 32'(AN), 32'h0000_00FB);
      chk("lz_slot2_seg", 32'(SEG), 32'h0000_0040);
`endif
      din[1] = 4'h0;
      wait_frame();
      run(FRAME_LEN);
      $display("leading-zero frames: slot2 checked");

      // Mid-slot reset at slot 3, scan restarts at slot 0.
      for (int i = 0; i < 8; i++) din[i] = 4'(i + 9);
      wait_frame();
      wait_pos(3 * DIV + 2);
      do_reset();
      cycle();
      chk("post_rst_blank", 32'(AN), 32'h0000_00FF);
      cycle();
      chk("post_rst_an0", 32'(AN), 32'h0000_00FE);
      chk("post_rst_seg0", 32'(SEG), 32'h0000_0040);
      $display("reset at slot 3: restart AN=%h SEG=%h", AN, SEG);

      // Randomized run against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0)
            din[$urandom_range(0, 7)] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) En = ~En;
         if ($urandom_range(0, 399) == 0) do_reset();
         cycle();
      end
      $display("random phase: %0d checks so far", n_checks);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
